// File: rtl/median_result_writer_if.sv
// FIFO-drain and frame-RAM write signals of the median result writer.
// The master modport is the writer; the slave modport is the FIFO/RAM side.
interface median_result_writer_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  pop;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output pop,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  pop,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/median_result_writer.sv
// Drains the median-filter output FIFO and writes one ROW x COL frame in raster
// order into the output frame RAM, pulsing done after the last write.
module median_result_writer #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROW        = 256,
    parameter int unsigned COL        = 256
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    median_result_writer_if.master io_bus,
    output logic [ADDR_WIDTH-1:0] o_row_idx,
    output logic [ADDR_WIDTH-1:0] o_col_idx,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] NPIX = CNT_W'(ROW * COL);
    localparam logic [CNT_W-1:0] NPIX_LAST = CNT_W'(ROW * COL - 1);
    localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(COL - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic                  w_pop;
    logic [CNT_W-1:0]      r_pop_cnt;
    logic [CNT_W-1:0]      r_wr_cnt;
    logic [ADDR_WIDTH-1:0] r_row_cnt;
    logic [ADDR_WIDTH-1:0] r_col_cnt;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] r_row_idx;
    logic [ADDR_WIDTH-1:0] r_col_idx;

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_start) w_state_next = StRun;
            end
            StRun: begin
                w_pop = !io_bus.fifo_empty && (r_pop_cnt < NPIX);
                if (w_pop && (r_pop_cnt == NPIX_LAST)) w_state_next = StFlush;
            end
            StFlush: w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_pop_cnt  <= '0;
            r_wr_cnt   <= '0;
            r_row_cnt  <= '0;
            r_col_cnt  <= '0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_row_idx  <= '0;
            r_col_idx  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_mem_we <= w_pop;
            if ((r_state == StIdle) && i_start) begin
                r_pop_cnt  <= '0;
                r_wr_cnt   <= '0;
                r_row_cnt  <= '0;
                r_col_cnt  <= '0;
                r_mem_addr <= '0;
                r_row_idx  <= '0;
                r_col_idx  <= '0;
            end else if (w_pop) begin
                // Write side is booked at pop time; data arrives with the write cycle.
                r_pop_cnt  <= r_pop_cnt + CNT_W'(1);
                if (r_wr_cnt != NPIX) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                r_mem_addr <= r_wr_cnt[ADDR_WIDTH-1:0];
                r_row_idx  <= r_row_cnt;
                r_col_idx  <= r_col_cnt;
                if (r_col_cnt == COL_LAST) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= r_row_cnt + ADDR_WIDTH'(1);
                end else begin
                    r_col_cnt <= r_col_cnt + ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign io_bus.pop       = w_pop;
    assign io_bus.mem_we    = r_mem_we;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_wdata = io_bus.fifo_data;
    assign o_row_idx        = r_row_idx;
    assign o_col_idx        = r_col_idx;
    assign o_busy           = (r_state == StRun) || (r_state == StFlush);
    assign o_done           = (r_state == StDone);
endmodule

// File: tb/tb_median_result_writer.sv
// Bench for median_result_writer: a queue-backed FIFO feeds the DUT and every
// frame is compared against raster-order expectations built from the pushed data.
module tb_median_result_writer;
    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 8;
    localparam int unsigned ROW  = 4;
    localparam int unsigned COL  = 4;
    localparam int unsigned NPIX = ROW * COL;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] row_idx;
    logic [AW-1:0] col_idx;
    logic          busy;
    logic          done;
    logic          f_empty = 1'b1;
    logic [DW-1:0] f_data  = '0;
    int            cyc     = 0;
    int            total   = 0;
    int            bad     = 0;
    int            feed_phase = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] feed_q[$];
    logic [DW-1:0] stream[$];
    int            pop_cyc[$];
    int            wr_cyc[$];
    int            done_cyc[$];
    int            busy_cyc[$];
    logic [AW-1:0] wr_addr[$];
    logic [AW-1:0] wr_row[$];
    logic [AW-1:0] wr_col[$];
    logic [DW-1:0] wr_data[$];

    median_result_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    assign bus.fifo_empty = f_empty;
    assign bus.fifo_data  = f_data;

    median_result_writer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .ROW       (ROW),
        .COL       (COL)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_start  (start),
        .io_bus   (bus),
        .o_row_idx(row_idx),
        .o_col_idx(col_idx),
        .o_busy   (busy),
        .o_done   (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: data appears the cycle after pop; empty flag is registered.
    always @(posedge clk) begin
        if (bus.pop === 1'b1) begin
            if (q.size() > 0) f_data <= q.pop_front();
            else f_data <= 'x;
        end
        if (feed_phase == 0 && feed_q.size() > 0) q.push_back(feed_q.pop_front());
        feed_phase <= (feed_phase == 2) ? 0 : feed_phase + 1;
        f_empty <= (q.size() == 0);
    end

    always @(negedge clk) begin
        if (bus.pop === 1'b1) pop_cyc.push_back(cyc);
        if (bus.mem_we === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
            wr_row.push_back(row_idx);
            wr_col.push_back(col_idx);
        end
        if (done === 1'b1) done_cyc.push_back(cyc);
        if (busy === 1'b1) busy_cyc.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        pop_cyc.delete();
        wr_cyc.delete();
        done_cyc.delete();
        busy_cyc.delete();
        wr_addr.delete();
        wr_row.delete();
        wr_col.delete();
        wr_data.delete();
    endtask

    task automatic push_word(input logic [DW-1:0] v);
        q.push_back(v);
        stream.push_back(v);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) push_word(DW'($urandom_range(255)));
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cyc.size() == 0 && n < 300) begin
            tick();
            n++;
        end
        chk({tag, " done timeout"}, 32'(n < 300), 1);
        repeat (3) tick();
    endtask

    // Expected frame: the next NPIX words of the input stream in raster order.
    task automatic check_frame(input string tag, input int s, input bit full);
        logic [DW-1:0] e;
        chk({tag, " writes"}, wr_addr.size(), NPIX);
        chk({tag, " pops"}, pop_cyc.size(), NPIX);
        chk({tag, " dones"}, done_cyc.size(), 1);
        for (int i = 0; i < int'(NPIX); i++) begin
            e = (stream.size() > 0) ? stream.pop_front() : 'x;
            if (i < wr_addr.size()) begin
                chk({tag, " addr"}, wr_addr[i], i);
                chk({tag, " data"}, wr_data[i], e);
                chk({tag, " row"}, wr_row[i], i / COL);
                chk({tag, " col"}, wr_col[i], i % COL);
                if (full) chk({tag, " write cycle"}, wr_cyc[i], s + 2 + i);
            end
            if (full && i < pop_cyc.size()) chk({tag, " pop cycle"}, pop_cyc[i], s + 1 + i);
        end
        if (done_cyc.size() > 0 && wr_cyc.size() > 0 && pop_cyc.size() > 0) begin
            chk({tag, " done after last write"}, done_cyc[0], wr_cyc[$] + 1);
            chk({tag, " done after last pop"}, done_cyc[0], pop_cyc[$] + 2);
        end
        if (full) begin
            if (done_cyc.size() > 0) chk({tag, " done cycle"}, done_cyc[0], s + NPIX + 2);
            chk({tag, " busy cycles"}, busy_cyc.size(), NPIX + 1);
            if (busy_cyc.size() > 0) chk({tag, " busy first"}, busy_cyc[0], s + 1);
        end
    endtask

    initial begin
        int s;
        int s2;
        int n;
        logic [DW-1:0] v;

        repeat (3) tick();
        chk("reset pop", bus.pop, 0);
        chk("reset mem_we", bus.mem_we, 0);
        chk("reset addr", bus.mem_addr, 0);
        chk("reset row", row_idx, 0);
        chk("reset col", col_idx, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        rst = 1'b0;
        tick();

        // Full-rate frame with 0x10..0x1F preloaded.
        for (int i = 0; i < 16; i++) push_word(DW'(8'h10 + i));
        tick();
        clear_logs();
        pulse_start(s);
        wait_done("full");
        if (wr_row.size() > 5) begin
            chk("full row@5", wr_row[5], 1);
            chk("full col@5", wr_col[5], 1);
        end
        check_frame("full", s, 1'b1);

        // Bubbles: one word every 3 cycles.
        clear_logs();
        for (int i = 0; i < int'(NPIX); i++) begin
            v = DW'($urandom_range(255));
            feed_q.push_back(v);
            stream.push_back(v);
        end
        pulse_start(s);
        wait_done("bub");
        for (int i = 1; i < wr_cyc.size(); i++)
            chk("bub isolated write", 32'((wr_cyc[i] - wr_cyc[i-1]) > 1), 1);
        check_frame("bub", s, 1'b0);

        // Overfill: 20 words, only 16 may be consumed.
        push_rand(20);
        tick();
        clear_logs();
        pulse_start(s);
        wait_done("ovf");
        repeat (3) tick();
        chk("ovf leftover", q.size(), 4);
        if (pop_cyc.size() > 0) chk("ovf last pop", pop_cyc[$], s + NPIX);
        check_frame("ovf", s, 1'b1);

        // Start while busy at cycle 5 of the frame.
        push_rand(12);
        tick();
        clear_logs();
        pulse_start(s);
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("sbusy");
        check_frame("sbusy", s, 1'b1);

        // Reset during the 7th pop.
        push_rand(16);
        tick();
        clear_logs();
        pulse_start(s);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst mem_we", bus.mem_we, 0);
        chk("rst addr", bus.mem_addr, 0);
        chk("rst row", row_idx, 0);
        chk("rst col", col_idx, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst pop idle", bus.pop, 0);
        repeat (3) tick();
        chk("rst pops", pop_cyc.size(), 7);
        chk("rst writes", wr_addr.size(), 6);
        chk("rst dones", done_cyc.size(), 0);
        for (int i = 0; i < 6; i++) begin
            if (i < wr_addr.size() && i < stream.size()) begin
                chk("rst addr seq", wr_addr[i], i);
                chk("rst data seq", wr_data[i], stream[i]);
            end
        end
        for (int i = 0; i < 7; i++) if (stream.size() > 0) void'(stream.pop_front());
        push_rand(7);
        tick();
        clear_logs();
        pulse_start(s);
        wait_done("rst2");
        check_frame("rst2", s, 1'b1);

        // Back-to-back frames: second start the cycle after done.
        push_rand(32);
        tick();
        clear_logs();
        pulse_start(s);
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("b2b done timeout", 32'(n < 300), 1);
        @(negedge clk);
        #1;
        check_frame("b2b1", s, 1'b1);
        clear_logs();
        @(posedge clk);
        #2;
        pulse_start(s2);
        chk("b2b second start cycle", s2, s + NPIX + 3);
        wait_done("b2b2");
        check_frame("b2b2", s2, 1'b1);
        chk("fifo drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
